// File: rtl/ft232_pkg.sv
// Shared definitions for the FT232H burst transmit engine: header byte,
// FSM state encoding and skid-buffer depth.
package ft232_pkg;

    // Channel header byte is HDR_BASE with the channel index in the low nibble.
    localparam logic [7:0] HDR_BASE = 8'hA0;

    // Depth of the skid FIFO that absorbs RAM reads while TXE# is high.
    localparam int SKID_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } tx_state_e;

    function automatic logic [7:0] hdr_byte(input logic [3:0] ch);
        return HDR_BASE | {4'h0, ch};
    endfunction

endpackage

// File: rtl/ft232_skid_fifo.sv
// Two-entry byte FIFO between the RAM read port and the FT232H output register.
// Push on a full FIFO is only honoured together with a pop; pop on empty is ignored.
module ft232_skid_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic [1:0] occ_o
);

    logic [7:0] slot_q [2];
    logic [7:0] slot_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] occ_q, occ_d;
    logic       do_push, do_pop;

    assign do_pop  = pop_i && (occ_q != 2'd0);
    assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

    // Next-state: write slot, pointer advance and occupancy update.
    always_comb begin
        slot_d   = slot_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            slot_d[wr_ptr_q] = din_i;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage and pointer registers, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= 8'h00;
            slot_q[1] <= 8'h00;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
        end
    end

    assign dout_o = slot_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/ft232h_burst_tx.sv
// FT232H synchronous-FIFO transmit engine. Streams one burst from a RAM bank
// to ADBUS/WR#, throttled by TXE#, with optional header byte and SIWU# flush.
module ft232h_burst_tx
    import ft232_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int LEN_W       = 12,
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter bit HDR_EN      = 1'b1,
    parameter bit SIWU_EN     = 1'b1,
    parameter int DONE_CYCLES = 2
) (
    input  logic              clockout,
    input  logic              rst_n,
    output logic [7:0]        adbus,
    input  logic              txe_n,
    output logic              wr_n,
    output logic              siwu_n,
    output logic              rd_clk,
    output logic [CH_W-1:0]   rd_ch,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              tr_go,
    input  logic [CH_W-1:0]   tr_ch,
    input  logic [LEN_W-1:0]  tr_len,
    output logic              tr_busy,
    output logic              tr_done,
    output logic              tr_err,
    output tx_state_e         dbg_state
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam int               DCNT_W  = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

    tx_state_e          state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fetched_q, fetched_d;
    logic [LEN_W-1:0]   sent_q, sent_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               inflight_q, inflight_d;
    logic [7:0]         obuf_q, obuf_d;
    logic               wr_n_q, wr_n_d;
    logic               siwu_n_q, siwu_n_d;
    logic               err_q, err_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;

    logic       go_ok, ch_ok, streaming;
    logic       ovalid, accept, out_free, load_out;
    logic       fetch_stream, fifo_push, fifo_pop;
    logic [7:0] fifo_dout;
    logic [1:0] fifo_occ;

    // Handshake: the output register holds a byte iff wr_n is low; the byte is
    // transferred on a rising edge where wr_n and txe_n are both low. While
    // txe_n is high, adbus and wr_n hold, so nothing is lost or repeated.
    assign ovalid   = !wr_n_q;
    assign accept   = ovalid && !txe_n;
    assign out_free = !ovalid || accept;

    // Channels beyond the populated banks are refused along with bad lengths.
    assign ch_ok = {{(32 - CH_W){1'b0}}, tr_ch} < 32'(NUM_CH);
    assign go_ok = tr_go && (state_q == ST_IDLE) && (tr_len != '0)
                   && (tr_len <= MAX_LEN) && ch_ok;

    assign streaming = (state_q == ST_HDR) || (state_q == ST_DATA);

    // The output register takes the oldest byte: FIFO head first, otherwise the
    // RAM word arriving this cycle (bypass keeps 1 byte/clock with no bubble).
    assign load_out  = streaming && out_free && ((fifo_occ != 2'd0) || inflight_q);
    assign fifo_pop  = load_out && (fifo_occ != 2'd0);
    assign fifo_push = inflight_q && !(load_out && (fifo_occ == 2'd0));

    // Keep at most SKID_DEPTH bytes either buffered or on their way from RAM.
    assign fetch_stream = streaming
                          && (({1'b0, fifo_occ} + {2'b00, inflight_q}) < 3'(SKID_DEPTH))
                          && (fetched_q < len_q);

    ft232_skid_fifo u_skid (
        .clk    (clockout),
        .rst_n  (rst_n),
        .push_i (fifo_push),
        .din_i  (rd_data),
        .pop_i  (fifo_pop),
        .dout_o (fifo_dout),
        .occ_o  (fifo_occ)
    );

    // FSM next state plus fetch, output-register and pulse next-state logic.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        len_d      = len_q;
        fetched_d  = fetched_q;
        sent_d     = sent_q;
        addr_d     = addr_q;
        inflight_d = go_ok || fetch_stream;
        obuf_d     = obuf_q;
        wr_n_d     = wr_n_q;
        err_d      = tr_go && !go_ok;
        dcnt_d     = dcnt_q;
        siwu_n_d   = 1'b1;

        if (load_out) begin
            obuf_d = (fifo_occ != 2'd0) ? fifo_dout : rd_data;
            wr_n_d = 1'b0;
        end else if (accept) begin
            wr_n_d = 1'b1;
        end

        // rd_addr only advances when another fetch will follow, so it parks on
        // the last address of the burst and never wraps on a full bank.
        if (fetch_stream) begin
            fetched_d = fetched_q + ONE_L;
            if ((fetched_q + ONE_L) < len_q) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (go_ok) begin
                    // Address 0 is read on this same edge, so count it as fetched.
                    ch_d      = tr_ch;
                    len_d     = tr_len;
                    fetched_d = ONE_L;
                    sent_d    = '0;
                    dcnt_d    = '0;
                    addr_d    = (tr_len > ONE_L) ? ADDR_W'(1) : '0;
                    if (HDR_EN) begin
                        obuf_d  = hdr_byte(4'(tr_ch));
                        wr_n_d  = 1'b0;
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_HDR: begin
                if (accept) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    sent_d = sent_q + ONE_L;
                    if ((sent_q + ONE_L) == len_q) begin
                        state_d = SIWU_EN ? ST_FLUSH : ST_DONE;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (dcnt_q == DCNT_W'(DONE_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SIWU# is low for exactly the single FLUSH cycle.
        if (state_d == ST_FLUSH) begin
            siwu_n_d = 1'b0;
        end
    end

    // State and datapath registers; reset aborts any burst without tr_done.
    always_ff @(posedge clockout or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            len_q      <= '0;
            fetched_q  <= '0;
            sent_q     <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            obuf_q     <= 8'h00;
            wr_n_q     <= 1'b1;
            siwu_n_q   <= 1'b1;
            err_q      <= 1'b0;
            dcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            len_q      <= len_d;
            fetched_q  <= fetched_d;
            sent_q     <= sent_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            obuf_q     <= obuf_d;
            wr_n_q     <= wr_n_d;
            siwu_n_q   <= siwu_n_d;
            err_q      <= err_d;
            dcnt_q     <= dcnt_d;
        end
    end

    assign adbus     = obuf_q;
    assign wr_n      = wr_n_q;
    assign siwu_n    = siwu_n_q;
    assign rd_clk    = clockout;
    assign rd_addr   = addr_q;
    // The first read is issued on the tr_go cycle, so the bank select follows
    // tr_ch then; afterwards it is the latched channel.
    assign rd_ch     = ((state_q == ST_IDLE) && tr_go) ? tr_ch : ch_q;
    assign tr_busy   = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_FLUSH);
    assign tr_done   = (state_q == ST_DONE);
    assign tr_err    = err_q;
    assign dbg_state = state_q;

endmodule
